// File: rtl/llrd_chain.sv
// llrd_chain: read-port engine of the link list manager.
// Takes a chain job, pulls pages from the free list one at a time and writes
// one link per page: each page points to its successor, and the last page
// points to stop_page. It then reports the head page and the chain length.
// Optional feature macro: LLRD_STATS_EN adds saturating page/chain counters.
module llrd_chain #(
  parameter int lpsz      = 8,
  parameter int lpdsz     = lpsz + 1,
  parameter int max_pages = 8,
  parameter int cntsz     = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  job_srdy,
  output logic                  job_drdy,
  input  logic [cntsz-1:0]      job_len,
  output logic                  pgreq,
  input  logic                  pgack,
  input  logic                  lprq_srdy,
  output logic                  lprq_drdy,
  input  logic [lpsz-1:0]       lprq_page,
  output logic                  lnp_srdy,
  input  logic                  lnp_drdy,
  output logic [lpsz+lpdsz-1:0] lnp_pnp,
  output logic                  op_srdy,
  input  logic                  op_drdy,
  output logic [lpsz-1:0]       op_page,
  output logic [cntsz-1:0]      op_cnt
`ifdef LLRD_STATS_EN
  ,
  output logic [31:0]           stat_pages,
  output logic [31:0]           stat_chains
`endif
);

  typedef enum logic [2:0] {IDLE, REQ, FETCH, LINK, LAST, SEND} state_t;

  localparam logic [cntsz-1:0] ONE       = cntsz'(1);
  localparam logic [cntsz-1:0] MAX_LEN   = cntsz'(max_pages);
  localparam logic [lpdsz-1:0] STOP_LINK = {1'b1, {(lpdsz-1){1'b0}}};

  state_t                  state_reg, state_next;
  logic [cntsz-1:0]        len_reg, len_next;
  logic [cntsz-1:0]        rem_reg, rem_next;
  logic [lpsz-1:0]         head_reg, head_next;
  logic [lpsz-1:0]         prev_reg, prev_next;
  logic                    first_reg, first_next;
  logic                    job_drdy_reg, job_drdy_next;
  logic                    pgreq_reg, pgreq_next;
  logic                    lprq_drdy_reg, lprq_drdy_next;
  logic                    lnp_srdy_reg, lnp_srdy_next;
  logic [lpsz+lpdsz-1:0]   lnp_pnp_reg, lnp_pnp_next;
  logic                    op_srdy_reg, op_srdy_next;
  logic [lpsz-1:0]         op_page_reg, op_page_next;
  logic [cntsz-1:0]        op_cnt_reg, op_cnt_next;

  logic [cntsz-1:0]        len_clamp;
  logic [cntsz-1:0]        rem_dec;
  logic                    job_xfer, grant, fetch_xfer, lnp_xfer, op_xfer;

  // Handshakes use the registered ready/valid so a transfer is exactly what
  // the neighbour sees on the wires.
  assign job_xfer   = job_srdy & job_drdy_reg;
  assign grant      = pgack & pgreq_reg;
  assign fetch_xfer = lprq_srdy & lprq_drdy_reg;
  assign lnp_xfer   = lnp_drdy & lnp_srdy_reg;
  assign op_xfer    = op_drdy & op_srdy_reg;

  // A zero-length job still builds a one-page chain; oversize jobs are capped.
  assign len_clamp = (job_len == '0)     ? ONE :
                     (job_len > MAX_LEN) ? MAX_LEN : job_len;
  assign rem_dec   = rem_reg - ONE;

  assign job_drdy  = job_drdy_reg;
  assign pgreq     = pgreq_reg;
  assign lprq_drdy = lprq_drdy_reg;
  assign lnp_srdy  = lnp_srdy_reg;
  assign lnp_pnp   = lnp_pnp_reg;
  assign op_srdy   = op_srdy_reg;
  assign op_page   = op_page_reg;
  assign op_cnt    = op_cnt_reg;

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      len_reg       <= '0;
      rem_reg       <= '0;
      head_reg      <= '0;
      prev_reg      <= '0;
      first_reg     <= 1'b0;
      job_drdy_reg  <= 1'b0;
      pgreq_reg     <= 1'b0;
      lprq_drdy_reg <= 1'b0;
      lnp_srdy_reg  <= 1'b0;
      lnp_pnp_reg   <= '0;
      op_srdy_reg   <= 1'b0;
      op_page_reg   <= '0;
      op_cnt_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      len_reg       <= len_next;
      rem_reg       <= rem_next;
      head_reg      <= head_next;
      prev_reg      <= prev_next;
      first_reg     <= first_next;
      job_drdy_reg  <= job_drdy_next;
      pgreq_reg     <= pgreq_next;
      lprq_drdy_reg <= lprq_drdy_next;
      lnp_srdy_reg  <= lnp_srdy_next;
      lnp_pnp_reg   <= lnp_pnp_next;
      op_srdy_reg   <= op_srdy_next;
      op_page_reg   <= op_page_next;
      op_cnt_reg    <= op_cnt_next;
    end
  end

  // Next-state and next-output decode; every output changes only on its own
  // handshake, so valid/data are held until accepted.
  always_comb begin
    state_next     = state_reg;
    len_next       = len_reg;
    rem_next       = rem_reg;
    head_next      = head_reg;
    prev_next      = prev_reg;
    first_next     = first_reg;
    job_drdy_next  = job_drdy_reg;
    pgreq_next     = pgreq_reg;
    lprq_drdy_next = lprq_drdy_reg;
    lnp_srdy_next  = lnp_srdy_reg;
    lnp_pnp_next   = lnp_pnp_reg;
    op_srdy_next   = op_srdy_reg;
    op_page_next   = op_page_reg;
    op_cnt_next    = op_cnt_reg;
    case (state_reg)
      IDLE: begin
        job_drdy_next = 1'b1;
        if (job_xfer) begin
          len_next      = len_clamp;
          rem_next      = len_clamp;
          first_next    = 1'b1;
          job_drdy_next = 1'b0;
          pgreq_next    = 1'b1;
          state_next    = REQ;
        end
      end
      REQ: begin
        if (grant) begin
          pgreq_next     = 1'b0;
          lprq_drdy_next = 1'b1;
          state_next     = FETCH;
        end
      end
      FETCH: begin
        if (fetch_xfer) begin
          rem_next       = rem_dec;
          lprq_drdy_next = 1'b0;
          prev_next      = lprq_page;
          if (first_reg) begin
            head_next  = lprq_page;
            first_next = 1'b0;
            if (rem_dec != '0) begin
              pgreq_next = 1'b1;
              state_next = REQ;
            end else begin
              lnp_srdy_next = 1'b1;
              lnp_pnp_next  = {lprq_page, STOP_LINK};
              state_next    = LAST;
            end
          end else begin
            lnp_srdy_next = 1'b1;
            lnp_pnp_next  = {prev_reg, lpdsz'(lprq_page)};
            state_next    = LINK;
          end
        end
      end
      LINK: begin
        if (lnp_xfer) begin
          if (rem_reg != '0) begin
            lnp_srdy_next = 1'b0;
            pgreq_next    = 1'b1;
            state_next    = REQ;
          end else begin
            lnp_pnp_next = {prev_reg, STOP_LINK};
            state_next   = LAST;
          end
        end
      end
      LAST: begin
        if (lnp_xfer) begin
          lnp_srdy_next = 1'b0;
          op_srdy_next  = 1'b1;
          op_page_next  = head_reg;
          op_cnt_next   = len_reg;
          state_next    = SEND;
        end
      end
      SEND: begin
        if (op_xfer) begin
          op_srdy_next  = 1'b0;
          job_drdy_next = 1'b1;
          state_next    = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef LLRD_STATS_EN
  logic [31:0] stat_pages_reg;
  logic [31:0] stat_chains_reg;

  assign stat_pages  = stat_pages_reg;
  assign stat_chains = stat_chains_reg;

  // Saturating usage counters, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_pages_reg  <= '0;
      stat_chains_reg <= '0;
    end else begin
      if (fetch_xfer && (state_reg == FETCH) && !(&stat_pages_reg))
        stat_pages_reg <= stat_pages_reg + 32'd1;
      if (op_xfer && !(&stat_chains_reg))
        stat_chains_reg <= stat_chains_reg + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_llrd_chain.sv
// tb_llrd_chain: directed and randomized jobs for llrd_chain, checked against
// a chain-level model (expected pages, link list, descriptor) in the bench.
module tb_llrd_chain;

  localparam int LPSZ  = 8;
  localparam int LPDSZ = 9;
  localparam int MAXP  = 8;
  localparam int CNTSZ = 4;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  job_srdy;
  logic                  job_drdy;
  logic [CNTSZ-1:0]      job_len;
  logic                  pgreq;
  logic                  pgack;
  logic                  lprq_srdy;
  logic                  lprq_drdy;
  logic [LPSZ-1:0]       lprq_page;
  logic                  lnp_srdy;
  logic                  lnp_drdy;
  logic [LPSZ+LPDSZ-1:0] lnp_pnp;
  logic                  op_srdy;
  logic                  op_drdy;
  logic [LPSZ-1:0]       op_page;
  logic [CNTSZ-1:0]      op_cnt;
`ifdef LLRD_STATS_EN
  logic [31:0]           stat_pages;
  logic [31:0]           stat_chains;
`endif

  int tests = 0;
  int fails = 0;
  int job_no = 0;
  int exp_pages_tot = 0;
  int exp_chains_tot = 0;
  int dir_pg[MAXP];

  always #5 clk = ~clk;

  llrd_chain #(.lpsz(LPSZ), .lpdsz(LPDSZ), .max_pages(MAXP), .cntsz(CNTSZ)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .job_srdy  (job_srdy),
    .job_drdy  (job_drdy),
    .job_len   (job_len),
    .pgreq     (pgreq),
    .pgack     (pgack),
    .lprq_srdy (lprq_srdy),
    .lprq_drdy (lprq_drdy),
    .lprq_page (lprq_page),
    .lnp_srdy  (lnp_srdy),
    .lnp_drdy  (lnp_drdy),
    .lnp_pnp   (lnp_pnp),
    .op_srdy   (op_srdy),
    .op_drdy   (op_drdy),
    .op_page   (op_page),
    .op_cnt    (op_cnt)
`ifdef LLRD_STATS_EN
    ,
    .stat_pages  (stat_pages),
    .stat_chains (stat_chains)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Link word the chain must contain: page in the top field, successor or stop below.
  function automatic logic [31:0] link_word(input int pg, input int nxt, input bit stop);
    logic [31:0] w;
    w = 32'(pg) << LPDSZ;
    if (stop) w = w | (32'd1 << (LPDSZ - 1));
    else      w = w | 32'(nxt);
    return w;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_job_drdy"},  32'(job_drdy),  32'd0);
    check({tag, "_pgreq"},     32'(pgreq),     32'd0);
    check({tag, "_lprq_drdy"}, 32'(lprq_drdy), 32'd0);
    check({tag, "_lnp_srdy"},  32'(lnp_srdy),  32'd0);
    check({tag, "_lnp_pnp"},   32'(lnp_pnp),   32'd0);
    check({tag, "_op_srdy"},   32'(op_srdy),   32'd0);
    check({tag, "_op_page"},   32'(op_page),   32'd0);
    check({tag, "_op_cnt"},    32'(op_cnt),    32'd0);
  endtask

  // Runs one chain job from job handshake to descriptor handshake. Called and
  // returns on a falling edge. bp enables random backpressure and stray strobes.
  task automatic run_job(input int jl, input bit bp, input bit use_dir);
    int  exp_len;
    int  pg[MAXP];
    int  grants, taken, links, cyc;
    bit  accepted, done;
    bit  jx, gx, fx, lx, ox;
    bit  p_pgreq, p_gx, p_lprq_drdy, p_fx, p_lnp_srdy, p_lx, p_op_srdy, p_ox;
    logic [31:0] p_pnp, p_op;
    logic [31:0] exp_w;

    exp_len = (jl == 0) ? 1 : ((jl > MAXP) ? MAXP : jl);
    for (int i = 0; i < MAXP; i++) pg[i] = use_dir ? dir_pg[i] : int'($urandom_range(0, 255));
    grants = 0; taken = 0; links = 0; cyc = 0;
    accepted = 0; done = 0;
    p_pgreq = 0; p_gx = 0; p_lprq_drdy = 0; p_fx = 0;
    p_lnp_srdy = 0; p_lx = 0; p_op_srdy = 0; p_ox = 0;
    p_pnp = '0; p_op = '0;

    while (!done && cyc < 3000) begin
      // Valid/ready that were up without a transfer must still be up, data unchanged.
      if (p_pgreq && !p_gx) check("pgreq_hold", 32'(pgreq), 32'd1);
      if (p_lprq_drdy && !p_fx) check("lprq_drdy_hold", 32'(lprq_drdy), 32'd1);
      if (p_lnp_srdy && !p_lx) begin
        check("lnp_srdy_hold", 32'(lnp_srdy), 32'd1);
        check("lnp_pnp_hold", 32'(lnp_pnp), p_pnp);
      end
      if (p_op_srdy && !p_ox) begin
        check("op_srdy_hold", 32'(op_srdy), 32'd1);
        check("op_data_hold", {16'd0, 8'(op_page), 4'd0, 4'(op_cnt)}, p_op);
      end

      job_srdy  = !accepted;
      job_len   = CNTSZ'(jl);
      pgack     = bp ? ($urandom_range(0, 2) == 0) : pgreq;
      lprq_srdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      lprq_page = (lprq_srdy && taken < exp_len) ? LPSZ'(pg[taken]) : LPSZ'($urandom);
      lnp_drdy  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      op_drdy   = bp ? 1'($urandom_range(0, 1)) : 1'b1;

      jx = job_srdy && (job_drdy === 1'b1);
      gx = (pgreq === 1'b1) && pgack;
      fx = lprq_srdy && (lprq_drdy === 1'b1);
      lx = (lnp_srdy === 1'b1) && lnp_drdy;
      ox = (op_srdy === 1'b1) && op_drdy;

      if (jx) accepted = 1;
      if (gx) begin
        check("grant_within_len", 32'(grants < exp_len), 32'd1);
        if (grants >= 2) check("link_before_next_req", 32'(links >= grants - 1), 32'd1);
        grants++;
      end
      if (fx) begin
        check("fetch_after_grant", 32'(taken < grants), 32'd1);
        taken++;
      end
      if (lx) begin
        check("link_within_len", 32'(links < exp_len), 32'd1);
        if (links < exp_len) begin
          if (links < exp_len - 1) exp_w = link_word(pg[links], pg[links + 1], 1'b0);
          else                     exp_w = link_word(pg[links], 0, 1'b1);
          check("lnp_pnp", 32'(lnp_pnp), exp_w);
        end
        links++;
      end
      if (ox) begin
        check("op_page", 32'(op_page), 32'(pg[0]));
        check("op_cnt", 32'(op_cnt), 32'(exp_len));
        check("link_count", 32'(links), 32'(exp_len));
        check("page_count", 32'(taken), 32'(exp_len));
        done = 1;
      end

      p_pgreq = (pgreq === 1'b1); p_gx = gx;
      p_lprq_drdy = (lprq_drdy === 1'b1); p_fx = fx;
      p_lnp_srdy = (lnp_srdy === 1'b1); p_lx = lx; p_pnp = 32'(lnp_pnp);
      p_op_srdy = (op_srdy === 1'b1); p_ox = ox;
      p_op = {16'd0, 8'(op_page), 4'd0, 4'(op_cnt)};

      @(posedge clk);
      @(negedge clk);
      cyc++;
    end

    job_srdy = 0; pgack = 0; lprq_srdy = 0; lnp_drdy = 0; op_drdy = 0;
    if (!done) check("job_timeout", 32'(done), 32'd1);
    else begin
      exp_pages_tot  += exp_len;
      exp_chains_tot += 1;
    end
    $display("[TB] job %0d len_in=%0d len=%0d head=0x%02h links=%0d cycles=%0d",
             job_no, jl, exp_len, pg[0], links, cyc);
    job_no++;
  endtask

  initial begin
    bit reached;
    reset_n = 0; job_srdy = 0; job_len = '0; pgack = 0;
    lprq_srdy = 0; lprq_page = '0; lnp_drdy = 0; op_drdy = 0;
    for (int i = 0; i < MAXP; i++) dir_pg[i] = 0;

    // Reset state and ready after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset_n = 1;
    @(negedge clk);
    check("idle_job_drdy", 32'(job_drdy), 32'd1);

    // Reset asserted while waiting for a free page.
    job_srdy = 1; job_len = CNTSZ'(2); reached = 0;
    for (int c = 0; c < 50 && !reached; c++) begin
      if (lprq_drdy === 1'b1) reached = 1;
      else begin
        pgack = pgreq;
        @(posedge clk);
        @(negedge clk);
      end
    end
    check("reach_fetch", 32'(reached), 32'd1);
    pgack = 0;
    #2 reset_n = 0;
    #1 check_all_zero("async_reset");
    job_srdy = 0;
    exp_pages_tot = 0; exp_chains_tot = 0;
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    check("post_reset_job_drdy", 32'(job_drdy), 32'd1);
    check("post_reset_pgreq", 32'(pgreq), 32'd0);
    $display("[TB] reset mid-fetch done");

    // Statistics jobs.
    run_job(2, 0, 0);
    run_job(4, 0, 0);
    run_job(1, 0, 0);
`ifdef LLRD_STATS_EN
    check("stat_pages", stat_pages, 32'(exp_pages_tot));
    check("stat_chains", stat_chains, 32'(exp_chains_tot));
`endif

    // Single page chain.
    dir_pg[0] = 'h05;
    run_job(1, 0, 1);

    // Three page chain.
    dir_pg[0] = 'h0A; dir_pg[1] = 'h0B; dir_pg[2] = 'h0C;
    run_job(3, 0, 1);

    // Length boundaries.
    run_job(0, 0, 0);
    run_job(15, 0, 0);
    run_job(8, 0, 0);

    // Random lengths with backpressure and stray strobes.
    for (int j = 0; j < 200; j++) run_job(int'($urandom_range(0, 15)), 1, 0);

`ifdef LLRD_STATS_EN
    check("stat_pages_end", stat_pages, 32'(exp_pages_tot));
    check("stat_chains_end", stat_chains, 32'(exp_chains_tot));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
